// File: rtl/l2_arb_pkg.sv
// Shared widths, FSM state encoding, requester ids and the latched
// transaction record for the two-requester L2 memory arbiter.
package l2_arb_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic              op_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

endpackage

// File: rtl/l2_arb_pick.sv
// Combinational owner selection between the I and D requesters.
// ARB_RR_EN selects round-robin; otherwise D has fixed priority over I.
module l2_arb_pick
  import l2_arb_pkg::*;
(
  input  logic i_req_i,
  input  logic i_req_d,
`ifdef ARB_RR_EN
  input  logic i_last,
`endif
  output logic o_grant,
  output logic o_owner
);

  assign o_grant = i_req_i | i_req_d;

`ifdef ARB_RR_EN
  // On contention the requester that did not win last time gets the port.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    o_owner = REQ_I;
    if (i_req_i && i_req_d) o_owner = (i_last == REQ_I) ? REQ_D : REQ_I;
    else if (i_req_d)       o_owner = REQ_D;
  end
`else
  assign o_owner = i_req_d ? REQ_D : REQ_I;
`endif

endmodule

// File: rtl/l2_mem_arbiter.sv
// Arbitrates the single 128-bit memory port between the I-side and D-side L2s.
// Define ARB_RR_EN for round-robin arbitration; default is fixed D-over-I priority.
module l2_mem_arbiter
  import l2_arb_pkg::*;
(
  input  logic              clk,
  input  logic              proc_reset_n,

  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,

  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_e        r_state;
  logic              r_owner;
  txn_t              r_txn;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_i_ready;
  logic              r_d_ready;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_i_act;
  logic              w_d_act;
  logic              w_grant;
  logic              w_owner;
  txn_t              w_req;

  assign w_i_act = i_read | i_write;
  assign w_d_act = d_read | d_write;

`ifdef ARB_RR_EN
  logic r_last;

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n)                   r_last <= REQ_I;
    else if (r_state == IDLE && w_grant) r_last <= w_owner;
  end

  l2_arb_pick u_pick (
    .i_req_i (w_i_act),
    .i_req_d (w_d_act),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_owner (w_owner)
  );
`else
  l2_arb_pick u_pick (
    .i_req_i (w_i_act),
    .i_req_d (w_d_act),
    .o_grant (w_grant),
    .o_owner (w_owner)
  );
`endif

  // A write wins when a requester raises read and write together.
  always_comb begin
    w_req = '0;
    if (w_owner == REQ_D) w_req = '{op_write: d_write, addr: d_addr, wdata: d_wdata};
    else                  w_req = '{op_write: i_write, addr: i_addr, wdata: i_wdata};
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      r_state     <= IDLE;
      r_owner     <= REQ_I;
      r_txn       <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_i_ready   <= 1'b0;
      r_d_ready   <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner     <= w_owner;
            r_txn       <= w_req;
            r_mem_write <= w_req.op_write;
            r_mem_read  <= ~w_req.op_write;
            r_state     <= BUSY;
          end
        end
        // Requester inputs are ignored here; only mem_ready ends the transaction.
        BUSY: begin
          if (mem_ready) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_owner == REQ_D) begin
              r_d_ready <= 1'b1;
              r_d_rdata <= mem_rdata;
            end else begin
              r_i_ready <= 1'b1;
              r_i_rdata <= mem_rdata;
            end
            r_state <= RESP;
          end
        end
        RESP: begin
          r_i_ready <= 1'b0;
          r_d_ready <= 1'b0;
          r_state   <= GAP;
        end
        GAP:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_txn.addr;
  assign mem_wdata = r_txn.wdata;
  assign i_ready   = r_i_ready;
  assign d_ready   = r_d_ready;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;

endmodule
